// File: rtl/synch_bin_count_down_if.sv
// Control and status bundle for the loadable down-counter / interval timer.
interface synch_bin_count_down_if #(
  parameter int unsigned NBITS = 4
);
  logic             ena;
  logic             load;
  logic [NBITS-1:0] load_val;
  logic             mode;
  logic [NBITS-1:0] counter;
  logic             zero;
  logic             tc;
  logic             running;

  // Controller side: drives the strobes and observes the count.
  modport master (
    output ena, load, load_val, mode,
    input  counter, zero, tc, running
  );

  // Counter side.
  modport slave (
    input  ena, load, load_val, mode,
    output counter, zero, tc, running
  );
endinterface

// File: rtl/synch_bin_count_down.sv
// Loadable binary down-counter with one-shot and periodic reload modes.
module synch_bin_count_down #(
  parameter int unsigned NBITS = 4
) (
  input logic                  clk,
  input logic                  rst,
  synch_bin_count_down_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned W = NBITS;

  state_t       state, state_next;
  logic [W-1:0] counter_q, counter_next;
  logic [W-1:0] reload_q, reload_next;
  logic         tc_q, tc_next;

  // State, count, reload value and terminal-count pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
    end else begin
      state     <= state_next;
      counter_q <= counter_next;
      reload_q  <= reload_next;
      tc_q      <= tc_next;
    end
  end

  // Next-state logic: load beats everything; a zero decision happens only
  // on an enabled edge in RUN, so ena gaps stretch timing without losing counts.
  always_comb begin
    state_next   = state;
    counter_next = counter_q;
    reload_next  = reload_q;
    tc_next      = 1'b0;

    if (bus.load) begin
      counter_next = bus.load_val;
      reload_next  = bus.load_val;
      state_next   = (bus.load_val != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // Hold; ena has no effect until a nonzero load.
        end
        RUN: begin
          if (bus.ena) begin
            if (counter_q > W'(1)) begin
              counter_next = counter_q - W'(1);
            end else if (counter_q == W'(1)) begin
              counter_next = '0;
              tc_next      = 1'b1;
              if (!bus.mode) state_next = IDLE;
            end else begin
              // Sitting at zero: periodic reloads, one-shot parks.
              if (bus.mode) counter_next = reload_q;
              else          state_next   = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Status outputs; zero is decoded straight from the count register.
  assign bus.counter = counter_q;
  assign bus.zero    = (counter_q == '0);
  assign bus.tc      = tc_q;
  assign bus.running = (state == RUN);

endmodule

// File: tb/tb_synch_bin_count_down.sv
// Randomised and directed check of synch_bin_count_down against a behavioural model.
module tb_synch_bin_count_down;
  localparam int unsigned NBITS = 4;
  localparam int MAXV = (1 << NBITS) - 1;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  bit   done;

  synch_bin_count_down_if #(.NBITS(NBITS)) bus ();

  synch_bin_count_down #(.NBITS(NBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: remaining count, reload value, armed flag, pulse.
  int m_cnt;
  int m_rel;
  bit m_run;
  bit m_tc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_rel = 0; m_run = 0; m_tc = 0;
    end else if (bus.load) begin
      m_cnt = int'(bus.load_val);
      m_rel = m_cnt;
      m_run = (m_cnt != 0);
      m_tc  = 0;
    end else if (m_run && bus.ena) begin
      if (m_cnt == 0) begin
        m_tc = 0;
        if (bus.mode) m_cnt = m_rel;
        else          m_run = 0;
      end else begin
        m_cnt = m_cnt - 1;
        m_tc  = (m_cnt == 0);
        if (m_cnt == 0 && !bus.mode) m_run = 0;
      end
    end else begin
      m_tc = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clk) begin
    if (!done) begin
      check("model_counter", int'(bus.counter), m_cnt);
      check("model_zero",    int'(bus.zero),    int'(m_cnt == 0));
      check("model_tc",      int'(bus.tc),      int'(m_tc));
      check("model_running", int'(bus.running), int'(m_run));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit l, input int lv, input bit e, input bit m);
    bus.load     = l;
    bus.load_val = NBITS'(lv);
    bus.ena      = e;
    bus.mode     = m;
  endtask

  task automatic lit(input string name, input int c, input int z, input int t, input int r);
    check({name, "_counter"}, int'(bus.counter), c);
    check({name, "_zero"},    int'(bus.zero),    z);
    check({name, "_tc"},      int'(bus.tc),      t);
    check({name, "_running"}, int'(bus.running), r);
  endtask

  initial begin
    int exp_seq[8];
    vectors = 0; miscompares = 0; done = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) cyc();
    lit("reset", 0, 1, 0, 0);
    rst = 1'b0;

    // ena ignored in IDLE after reset.
    drive(0, 0, 1, 1);
    repeat (4) cyc();
    lit("idle_ena", 0, 1, 0, 0);

    // One-shot: load 3 then 2,1,0 with one tc, then hold at 0.
    drive(1, 3, 0, 0); cyc(); lit("os_load", 3, 0, 0, 1);
    drive(0, 9, 1, 0); cyc(); lit("os_2", 2, 0, 0, 1);
    cyc(); lit("os_1", 1, 0, 0, 1);
    cyc(); lit("os_0", 0, 1, 1, 0);
    cyc(); lit("os_hold", 0, 1, 0, 0);

    // Periodic: load 2, sequence 1,0,2,1,0,2,1,0.
    drive(1, 2, 1, 1); cyc(); lit("per_load", 2, 0, 0, 1);
    drive(0, 5, 1, 1);
    exp_seq = '{1, 0, 2, 1, 0, 2, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cyc();
      lit("per_seq", exp_seq[i], int'(exp_seq[i] == 0), int'(exp_seq[i] == 0), 1);
    end

    // Enable gaps from max value: 15,14,14,13,13 then 13 more enabled edges.
    drive(1, MAXV, 0, 0); cyc(); lit("gap_load", 15, 0, 0, 1);
    drive(0, 0, 1, 0); cyc(); lit("gap_a", 14, 0, 0, 1);
    drive(0, 0, 0, 0); cyc(); lit("gap_b", 14, 0, 0, 1);
    drive(0, 0, 1, 0); cyc(); lit("gap_c", 13, 0, 0, 1);
    drive(0, 0, 0, 0); cyc(); lit("gap_d", 13, 0, 0, 1);
    drive(0, 0, 1, 0);
    repeat (12) cyc();
    lit("gap_one", 1, 0, 0, 1);
    cyc(); lit("gap_zero", 0, 1, 1, 0);

    // Load collisions with a terminal-count decision.
    drive(1, 1, 0, 0); cyc(); lit("col_pre", 1, 0, 0, 1);
    drive(1, 7, 1, 0); cyc(); lit("col_load7", 7, 0, 0, 1);
    drive(1, 0, 1, 0); cyc(); lit("col_load0", 0, 1, 0, 0);

    // Mode change mid-run: periodic load 4, switch to one-shot at 2.
    drive(1, 4, 0, 1); cyc(); lit("mc_load", 4, 0, 0, 1);
    drive(0, 0, 1, 1); cyc(); cyc(); lit("mc_2", 2, 0, 0, 1);
    drive(0, 0, 1, 0); cyc(); lit("mc_1", 1, 0, 0, 1);
    cyc(); lit("mc_0", 0, 1, 1, 0);
    cyc(); lit("mc_idle", 0, 1, 0, 0);

    // Asynchronous reset mid-count at 5.
    drive(1, 9, 1, 0); cyc();
    drive(0, 0, 1, 0); repeat (4) cyc(); lit("rst_pre", 5, 0, 0, 1);
    rst = 1'b1; #1;
    lit("rst_async", 0, 1, 0, 0);
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    lit("rst_idle", 0, 1, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.ena  = ($urandom_range(0, 3) != 0);
      bus.load = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       bus.load_val = '0;
        1:       bus.load_val = NBITS'(1);
        default: bus.load_val = NBITS'($urandom);
      endcase
      if ($urandom_range(0, 31) == 0) bus.mode = ~bus.mode;
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0;

    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
